// File: rtl/ahblite_decoder_mux.sv
// AHB-Lite address decoder, registered data-phase response mux and built-in default slave.
// Unmapped NONSEQ/SEQ accesses get a two-cycle ERROR; the last fault address and a saturating count are logged.
module ahblite_decoder_mux #(
  parameter int                      NUM_PORTS  = 6,
  parameter logic [32*NUM_PORTS-1:0] BASE_ADDRS = {32'h4001_0000, 32'h4000_0000, 32'h4000_0010,
                                                   32'h4005_0000, 32'h2000_0000, 32'h0000_0000},
  parameter logic [32*NUM_PORTS-1:0] ADDR_MASKS = {32'hFFFF_0000, 32'hFFFF_FFF0, 32'hFFFF_FFF0,
                                                   32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000},
  parameter logic [NUM_PORTS-1:0]    PORT_EN    = 6'b111111
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic [31:0]               HADDR,
  input  logic [1:0]                HTRANS,
  output logic [NUM_PORTS-1:0]      HSEL,
  input  logic [NUM_PORTS-1:0]      HREADYOUT_S,
  input  logic [NUM_PORTS-1:0]      HRESP_S,
  input  logic [32*NUM_PORTS-1:0]   HRDATA_S,
  output logic                      HREADY,
  output logic                      HRESP,
  output logic [31:0]               HRDATA,
  input  logic                      ERR_CLR,
  output logic [31:0]               FAULT_ADDR,
  output logic [7:0]                ERR_CNT
);

  typedef enum logic [1:0] {IDLE, ERR1, ERR2} state_e;

  state_e               state_q, state_d;
  logic [NUM_PORTS:0]   sel_dp_q, sel_dp_d;
  logic [31:0]          fault_addr_q, fault_addr_d;
  logic [7:0]           err_cnt_q, err_cnt_d;
  logic                 found;
  logic                 default_sel;
  logic                 err_start;
  logic                 err_entry;
  logic                 def_ready;
  logic                 def_resp;
  logic                 unused_htrans0;

  assign unused_htrans0 = HTRANS[0];

  // Lowest-index match wins; the found flag blocks later ports.
  always_comb begin
    HSEL  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!found && PORT_EN[i] &&
          ((HADDR & ADDR_MASKS[32*i +: 32]) == (BASE_ADDRS[32*i +: 32] & ADDR_MASKS[32*i +: 32]))) begin
        HSEL[i] = 1'b1;
        found   = 1'b1;
      end
    end
    default_sel = ~found;
  end

  assign sel_dp_d = HREADY ? {default_sel, HSEL} : sel_dp_q;

  // Moore outputs kept apart from next-state logic so HREADY never loops through the FSM.
  assign def_ready = (state_q != ERR1);
  assign def_resp  = (state_q != IDLE);

  always_comb begin
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = '0;
    if (sel_dp_q[NUM_PORTS]) begin
      HREADY = def_ready;
      HRESP  = def_resp;
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (sel_dp_q[i]) begin
        HREADY = HREADYOUT_S[i];
        HRESP  = HRESP_S[i];
        HRDATA = HRDATA_S[32*i +: 32];
      end
    end
  end

  assign err_start = HREADY & default_sel & HTRANS[1];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (err_start) state_d = ERR1;
      ERR1:    state_d = ERR2;
      ERR2:    state_d = err_start ? ERR1 : IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign err_entry = (state_d == ERR1);

  always_comb begin
    fault_addr_d = fault_addr_q;
    err_cnt_d    = err_cnt_q;
    if (err_entry) begin
      fault_addr_d = HADDR;
      if (ERR_CLR)                 err_cnt_d = 8'd1;
      else if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end else if (ERR_CLR) begin
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q      <= IDLE;
      sel_dp_q     <= '0;
      fault_addr_q <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      sel_dp_q     <= sel_dp_d;
      fault_addr_q <= fault_addr_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign FAULT_ADDR = fault_addr_q;
  assign ERR_CNT    = err_cnt_q;

endmodule

// File: tb/tb_ahblite_decoder_mux.sv
// Directed bench: stimulus queues per-cycle expectations, a negedge monitor pops and compares them.
// Instance b disables port 0 so the same traffic exercises the PORT_EN path.
module tb_ahblite_decoder_mux;
  localparam int NP = 6;
  localparam int S_HSEL = 0, S_RDY = 1, S_RESP = 2, S_RDATA = 3, S_FADDR = 4, S_CNT = 5;
  localparam int S_HSEL_B = 6, S_RDY_B = 7, S_RESP_B = 8, S_RDATA_B = 9, S_CNT_B = 10, S_FADDR_B = 11;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic            hclk = 1'b0;
  logic            hreset;
  logic [31:0]     haddr;
  logic [1:0]      htrans;
  logic [NP-1:0]   hreadyout_s;
  logic [NP-1:0]   hresp_s;
  logic [32*NP-1:0] hrdata_s;
  logic            err_clr;
  logic [NP-1:0]   hsel, hsel_b;
  logic            hready, hready_b, hresp, hresp_b;
  logic [31:0]     hrdata, hrdata_b, fault_addr, fault_addr_b;
  logic [7:0]      err_cnt, err_cnt_b;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  always #5 hclk = ~hclk;
  always @(posedge hclk) cyc <= cyc + 1;

  ahblite_decoder_mux dut (
    .HCLK(hclk), .HRESET(hreset), .HADDR(haddr), .HTRANS(htrans), .HSEL(hsel),
    .HREADYOUT_S(hreadyout_s), .HRESP_S(hresp_s), .HRDATA_S(hrdata_s),
    .HREADY(hready), .HRESP(hresp), .HRDATA(hrdata),
    .ERR_CLR(err_clr), .FAULT_ADDR(fault_addr), .ERR_CNT(err_cnt)
  );

  ahblite_decoder_mux #(.PORT_EN(6'b111110)) dut_b (
    .HCLK(hclk), .HRESET(hreset), .HADDR(haddr), .HTRANS(htrans), .HSEL(hsel_b),
    .HREADYOUT_S(hreadyout_s), .HRESP_S(hresp_s), .HRDATA_S(hrdata_s),
    .HREADY(hready_b), .HRESP(hresp_b), .HRDATA(hrdata_b),
    .ERR_CLR(err_clr), .FAULT_ADDR(fault_addr_b), .ERR_CNT(err_cnt_b)
  );

  function automatic logic [31:0] actual(input int sig);
    case (sig)
      S_HSEL:    actual = 32'(hsel);
      S_RDY:     actual = 32'(hready);
      S_RESP:    actual = 32'(hresp);
      S_RDATA:   actual = hrdata;
      S_FADDR:   actual = fault_addr;
      S_CNT:     actual = 32'(err_cnt);
      S_HSEL_B:  actual = 32'(hsel_b);
      S_RDY_B:   actual = 32'(hready_b);
      S_RESP_B:  actual = 32'(hresp_b);
      S_RDATA_B: actual = hrdata_b;
      S_CNT_B:   actual = 32'(err_cnt_b);
      S_FADDR_B: actual = fault_addr_b;
      default:   actual = 32'hDEAD_BEEF;
    endcase
  endfunction

  always @(negedge hclk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (mon_e.cyc != cyc || actual(mon_e.sig) !== mon_e.val) begin
        failures++;
        $display("FAIL %s: got %h expected %h (cycle %0d, due %0d)",
                 mon_e.name, actual(mon_e.sig), mon_e.val, cyc, mon_e.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic chk(input int sig, input logic [31:0] val, input string name);
    exp_t e;
    e.cyc  = cyc;
    e.sig  = sig;
    e.val  = val;
    e.name = name;
    exp_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    hreset = 1'b1; haddr = '0; htrans = 2'b00; err_clr = 1'b0;
    hreadyout_s = '1; hresp_s = '0;
    for (int i = 0; i < NP; i++) hrdata_s[32*i +: 32] = 32'hD000_0000 + 32'(i);
    tick();
    tick();
    hreset = 1'b0;
    chk(S_RDY, 1, "rst_hready");      chk(S_RESP, 0, "rst_hresp");
    chk(S_RDATA, 0, "rst_hrdata");    chk(S_CNT, 0, "rst_err_cnt");
    chk(S_FADDR, 0, "rst_fault_addr");
    chk(S_HSEL, 32'h01, "hsel_0x0");  chk(S_HSEL_B, 0, "hsel_b_0x0_disabled");

    tick();
    chk(S_RDATA, 32'hD000_0000, "idle_mux_port0");
    haddr = 32'h2000_0004; htrans = 2'b10;
    chk(S_HSEL, 32'h02, "hsel_ramcode");

    tick();
    htrans = 2'b00; haddr = '0;
    hreadyout_s[1] = 1'b0; hrdata_s[63:32] = 32'hCAFE_F00D;
    chk(S_RDY, 0, "rd_wait_hready"); chk(S_RESP, 0, "rd_wait_hresp");

    tick();
    hreadyout_s[1] = 1'b1;
    chk(S_RDY, 1, "rd_done_hready"); chk(S_RDATA, 32'hCAFE_F00D, "rd_done_hrdata");
    chk(S_RESP, 0, "rd_done_hresp");
    haddr = 32'h4000_0014;
    chk(S_HSEL, 32'h08, "hsel_0x40000014");

    tick();
    haddr = 32'h4000_0004;
    chk(S_HSEL, 32'h10, "hsel_0x40000004");

    tick();
    haddr = 32'h4000_0020;
    chk(S_HSEL, 0, "hsel_unmapped");

    tick();
    haddr = 32'h4001_0010;
    chk(S_HSEL, 32'h20, "hsel_port5");
    chk(S_RDY, 1, "idle_unmapped_hready"); chk(S_RESP, 0, "idle_unmapped_hresp");
    chk(S_RDATA, 0, "default_hrdata");

    tick();
    haddr = 32'h4005_0000;
    chk(S_HSEL, 32'h04, "hsel_port2"); chk(S_CNT, 0, "idle_no_count");

    tick();
    haddr = 32'h8000_0000; htrans = 2'b10;
    chk(S_HSEL, 0, "hsel_0x80000000");

    tick();
    htrans = 2'b00;
    chk(S_RDY, 0, "err1_hready"); chk(S_RESP, 1, "err1_hresp");
    chk(S_FADDR, 32'h8000_0000, "err_fault_addr"); chk(S_CNT, 1, "err_cnt_1");
    chk(S_RDATA, 0, "err1_hrdata");

    tick();
    chk(S_RDY, 1, "err2_hready"); chk(S_RESP, 1, "err2_hresp");

    tick();
    chk(S_RDY, 1, "post_err_hready"); chk(S_RESP, 0, "post_err_hresp");
    chk(S_CNT, 1, "idle_unmapped_no_count");

    for (int k = 0; k < 256; k++) begin
      haddr = 32'h9000_0000 + 32'(4 * k); htrans = 2'b10;
      tick();
      if (k == 1) begin
        chk(S_RDY, 0, "b2b_err1_hready"); chk(S_RESP, 1, "b2b_err1_hresp");
      end
      if (k == 252) chk(S_CNT, 254, "cnt_254");
      if (k == 253) chk(S_CNT, 255, "cnt_255");
      if (k == 255) chk(S_CNT, 255, "cnt_saturated");
      tick();
    end
    htrans = 2'b00;
    chk(S_CNT, 255, "cnt_sat_hold"); chk(S_FADDR, 32'h9000_03FC, "sat_fault_addr");
    chk(S_RDY, 1, "sat_err2_hready"); chk(S_RESP, 1, "sat_err2_hresp");

    tick();
    haddr = 32'hA000_0000; htrans = 2'b10; err_clr = 1'b1;
    chk(S_CNT, 255, "pre_clr_cnt");

    tick();
    err_clr = 1'b0; htrans = 2'b00;
    chk(S_CNT, 1, "clr_with_entry_cnt"); chk(S_FADDR, 32'hA000_0000, "clr_fault_addr");
    chk(S_RDY, 0, "clr_err1_hready");

    tick();
    tick();
    err_clr = 1'b1;
    chk(S_RESP, 0, "clr_idle_hresp");

    tick();
    err_clr = 1'b0;
    chk(S_CNT, 0, "clr_alone_cnt"); chk(S_FADDR, 32'hA000_0000, "clr_keeps_fault_addr");

    haddr = 32'h0000_0100; htrans = 2'b10;
    chk(S_HSEL, 32'h01, "hsel_0x100"); chk(S_HSEL_B, 0, "hsel_b_0x100");

    tick();
    htrans = 2'b00; hreset = 1'b1;
    chk(S_RDY_B, 0, "dis_err1_hready"); chk(S_RESP_B, 1, "dis_err1_hresp");
    chk(S_RDATA_B, 0, "dis_err1_hrdata"); chk(S_CNT_B, 1, "dis_err_cnt");
    chk(S_RDY, 1, "en_port0_hready"); chk(S_RESP, 0, "en_port0_hresp");
    chk(S_RDATA, 32'hD000_0000, "en_port0_hrdata");

    tick();
    hreset = 1'b0;
    chk(S_RDY_B, 1, "rst_err1_hready"); chk(S_RESP_B, 0, "rst_err1_hresp");
    chk(S_CNT_B, 0, "rst_err1_cnt");    chk(S_FADDR_B, 0, "rst_err1_faddr");
    chk(S_RDATA_B, 0, "rst_err1_hrdata"); chk(S_CNT, 0, "rst_a_cnt");

    tick();
    chk(S_RDY_B, 1, "rst_fsm_idle_hready"); chk(S_RESP_B, 0, "rst_fsm_idle_hresp");

    tick();
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) tick();
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
